ga_generation_ctrl: RTL and testbench

GA_GENERATION_CTRL -- requirements
Module: ga_generation_ctrl

---
 rtl/ga_generation_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_ga_generation_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ga_generation_ctrl.sv
// ---------------------------------------------------------------------------
// ga_generation_ctrl
//
// Sequencer for one genetic-algorithm run. For each generation it asks an
// external fitness unit to score every chromosome (one request per index),
// asks an external sorter to rank the population, then asks an external
// mating unit to rebuild ranks 2..POP_SIZE-1 from neighbouring parents.
// Ranks 0 and 1 are kept as elites. The run stops after max_gen
// generations, or on abort.
//
// Optional feature (compile-time macro GA_EARLY_EXIT_EN):
//   when defined, a fitness score of zero (perfect match) ends the run
//   immediately after that score is stored; generation is not incremented.
//
// Ports
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   start, abort    : run request (IDLE/FINISH only), return-to-idle request
//   max_gen         : generation limit, captured when start is accepted
//   fit_start/fit_idx/fit_done/fit_value : fitness-unit handshake
//   sort_start/sort_done                 : sorter handshake
//   fitness_array   : stored scores, entry i at [i*WIDTH +: WIDTH]
//   mate_start/mate_p1_rank/mate_p2_rank/child_idx/mate_done : mating handshake
//   busy, done      : run in progress, run finished (held in FINISH)
//   generation      : completed generations (saturating)
//   best_fitness    : lowest score seen since the last accepted start
// ---------------------------------------------------------------------------
module ga_generation_ctrl #(
  parameter int POP_SIZE = 10,
  parameter int WIDTH    = 5,
  parameter int GEN_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [GEN_W-1:0]              max_gen,
  output logic                          fit_start,
  output logic [$clog2(POP_SIZE)-1:0]   fit_idx,
  input  logic                          fit_done,
  input  logic [WIDTH-1:0]              fit_value,
  output logic                          sort_start,
  input  logic                          sort_done,
  output logic [POP_SIZE*WIDTH-1:0]     fitness_array,
  output logic                          mate_start,
  output logic [$clog2(POP_SIZE)-1:0]   mate_p1_rank,
  output logic [$clog2(POP_SIZE)-1:0]   mate_p2_rank,
  output logic [$clog2(POP_SIZE)-1:0]   child_idx,
  input  logic                          mate_done,
  output logic                          busy,
  output logic                          done,
  output logic [GEN_W-1:0]              generation,
  output logic [WIDTH-1:0]              best_fitness
);

  localparam int IDX_W = $clog2(POP_SIZE);
  localparam int H     = POP_SIZE / 2;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(POP_SIZE - 1);
  localparam logic [IDX_W-1:0] LAST_RANK = IDX_W'(H - 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FIT_REQ   = 4'd1,
    FIT_WAIT  = 4'd2,
    SORT_REQ  = 4'd3,
    SORT_WAIT = 4'd4,
    MATE_REQ  = 4'd5,
    MATE_WAIT = 4'd6,
    NEXT_GEN  = 4'd7,
    FINISH    = 4'd8
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic               w_start_acc;
  logic               w_fit_acc;
  logic               w_sort_acc;
  logic               w_mate_acc;
  logic               w_gen_step;
  logic [GEN_W:0]     w_gen_plus1;

  logic               r_fit_start;
  logic               r_sort_start;
  logic               r_mate_start;
  logic               r_busy;
  logic               r_done;
  logic [GEN_W-1:0]   r_generation;
  logic [GEN_W-1:0]   r_max_gen;
  logic [IDX_W-1:0]   r_fit_idx;
  logic [IDX_W-1:0]   r_child_idx;
  logic [IDX_W-1:0]   r_p1_rank;
  logic [IDX_W-1:0]   r_p2_rank;
  logic [WIDTH-1:0]   r_best;
  logic [WIDTH-1:0]   r_fit_arr [POP_SIZE];

  // One extra bit so a saturated counter still compares as "reached the limit".
  assign w_gen_plus1 = {1'b0, r_generation} + (GEN_W+1)'(1);

  // Next-state decode and handshake-acceptance strobes.
  always_comb begin
    w_next_state = r_state;
    w_start_acc  = 1'b0;
    w_fit_acc    = 1'b0;
    w_sort_acc   = 1'b0;
    w_mate_acc   = 1'b0;
    w_gen_step   = 1'b0;
    if (abort) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE, FINISH: begin
          if (start) begin
            w_start_acc  = 1'b1;
            w_next_state = (max_gen == '0) ? FINISH : FIT_REQ;
          end else begin
            w_next_state = r_state;
          end
        end
        FIT_REQ:  w_next_state = FIT_WAIT;
        FIT_WAIT: begin
          if (fit_done) begin
            w_fit_acc = 1'b1;
`ifdef GA_EARLY_EXIT_EN
            if (fit_value == '0) begin
              w_next_state = FINISH;
            end else if (r_fit_idx == LAST_IDX) begin
              w_next_state = SORT_REQ;
            end else begin
              w_next_state = FIT_REQ;
            end
`else
            if (r_fit_idx == LAST_IDX) begin
              w_next_state = SORT_REQ;
            end else begin
              w_next_state = FIT_REQ;
            end
`endif
          end else begin
            w_next_state = FIT_WAIT;
          end
        end
        SORT_REQ:  w_next_state = SORT_WAIT;
        SORT_WAIT: begin
          if (sort_done) begin
            w_sort_acc   = 1'b1;
            w_next_state = MATE_REQ;
          end else begin
            w_next_state = SORT_WAIT;
          end
        end
        MATE_REQ:  w_next_state = MATE_WAIT;
        MATE_WAIT: begin
          if (mate_done) begin
            w_mate_acc   = 1'b1;
            w_next_state = (r_child_idx == LAST_IDX) ? NEXT_GEN : MATE_REQ;
          end else begin
            w_next_state = MATE_WAIT;
          end
        end
        NEXT_GEN: begin
          w_gen_step   = 1'b1;
          w_next_state = (w_gen_plus1 >= {1'b0, r_max_gen}) ? FINISH : FIT_REQ;
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Registered strobes and status, decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fit_start  <= 1'b0;
      r_sort_start <= 1'b0;
      r_mate_start <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_fit_start  <= (w_next_state == FIT_REQ);
      r_sort_start <= (w_next_state == SORT_REQ);
      r_mate_start <= (w_next_state == MATE_REQ);
      r_busy       <= (w_next_state != IDLE) && (w_next_state != FINISH);
      r_done       <= (w_next_state == FINISH);
    end
  end

  // Datapath: counters, latched limit, score storage and best score.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_generation <= '0;
      r_max_gen    <= '0;
      r_fit_idx    <= '0;
      r_child_idx  <= '0;
      r_p1_rank    <= '0;
      r_p2_rank    <= '0;
      r_best       <= '1;
      for (int i = 0; i < POP_SIZE; i++) begin
        r_fit_arr[i] <= '0;
      end
    end else begin
      if (w_start_acc) begin
        r_generation <= '0;
        r_max_gen    <= max_gen;
        r_fit_idx    <= '0;
        r_best       <= '1;
      end
      if (w_fit_acc) begin
        r_fit_arr[r_fit_idx] <= fit_value;
        if (fit_value < r_best) begin
          r_best <= fit_value;
        end
        // Only advance when another fitness request follows; the last index
        // (or an early exit) leaves fit_idx on the chromosome just scored.
        if (w_next_state == FIT_REQ) begin
          r_fit_idx <= r_fit_idx + IDX_W'(1);
        end
      end
      if (w_sort_acc) begin
        // First rebuilt child is rank 2; its parents are ranks 0 and 1.
        r_child_idx <= IDX_W'(2);
        r_p1_rank   <= '0;
        r_p2_rank   <= IDX_W'(1);
      end
      if (w_mate_acc && (w_next_state == MATE_REQ)) begin
        // Parents track (child-2) mod H and (child-1) mod H incrementally.
        r_child_idx <= r_child_idx + IDX_W'(1);
        r_p1_rank   <= (r_p1_rank == LAST_RANK) ? '0 : r_p1_rank + IDX_W'(1);
        r_p2_rank   <= (r_p2_rank == LAST_RANK) ? '0 : r_p2_rank + IDX_W'(1);
      end
      if (w_gen_step) begin
        if (r_generation != '1) begin
          r_generation <= r_generation + GEN_W'(1);
        end
        if (w_next_state == FIT_REQ) begin
          r_fit_idx <= '0;
        end
      end
    end
  end

  for (genvar g = 0; g < POP_SIZE; g++) begin : g_flat
    assign fitness_array[g*WIDTH +: WIDTH] = r_fit_arr[g];
  end

  assign fit_start    = r_fit_start;
  assign fit_idx      = r_fit_idx;
  assign sort_start   = r_sort_start;
  assign mate_start   = r_mate_start;
  assign mate_p1_rank = r_p1_rank;
  assign mate_p2_rank = r_p2_rank;
  assign child_idx    = r_child_idx;
  assign busy         = r_busy;
  assign done         = r_done;
  assign generation   = r_generation;
  assign best_fitness = r_best;

endmodule

// File: tb/tb_ga_generation_ctrl.sv
// Bench for ga_generation_ctrl (POP_SIZE=10, WIDTH=5, GEN_W=8).
// The reference is an ordered list of handshake requests the run must issue,
// built from the generation/fitness/sort/mate rules, plus expected end state.
module tb_ga_generation_ctrl;

  localparam int POP = 10;
  localparam int W   = 5;
  localparam int GW  = 8;
  localparam int IW  = 4;
  localparam int H   = POP / 2;
`ifdef GA_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [GW-1:0]   max_gen = '0;
  logic            fit_start;
  logic [IW-1:0]   fit_idx;
  logic            fit_done = 1'b0;
  logic [W-1:0]    fit_value = '0;
  logic            sort_start;
  wire             sort_done;
  logic [POP*W-1:0] fitness_array;
  logic            mate_start;
  logic [IW-1:0]   mate_p1_rank, mate_p2_rank, child_idx;
  logic            mate_done = 1'b0;
  logic            busy, done;
  logic [GW-1:0]   generation;
  logic [W-1:0]    best_fitness;

  ga_generation_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .max_gen(max_gen),
    .fit_start(fit_start), .fit_idx(fit_idx), .fit_done(fit_done), .fit_value(fit_value),
    .sort_start(sort_start), .sort_done(sort_done), .fitness_array(fitness_array),
    .mate_start(mate_start), .mate_p1_rank(mate_p1_rank), .mate_p2_rank(mate_p2_rank),
    .child_idx(child_idx), .mate_done(mate_done),
    .busy(busy), .done(done), .generation(generation), .best_fitness(best_fitness)
  );

  always #5 clk = ~clk;

  // ---------------- responder (external units) ----------------
  int   vals [POP];
  bit   sort_auto = 1'b1;
  logic man_sort_done = 1'b0;
  int   abort_child = -1;
  logic auto_sort_done = 1'b0;
  bit   f_pend = 1'b0, s_pend = 1'b0, m_pend = 1'b0;
  int   f_pend_idx = 0, m_pend_child = 0;

  assign sort_done = sort_auto ? auto_sort_done : man_sort_done;

  // Each unit answers one cycle after it sees its request pulse.
  always @(negedge clk) begin
    if (rst) begin
      fit_done = 1'b0; auto_sort_done = 1'b0; mate_done = 1'b0; abort = 1'b0;
      f_pend = 1'b0; s_pend = 1'b0; m_pend = 1'b0;
    end else begin
      fit_done = f_pend;
      if (f_pend) fit_value = W'(vals[f_pend_idx]);
      f_pend = fit_start;
      f_pend_idx = int'(fit_idx);
      auto_sort_done = s_pend;
      s_pend = sort_start;
      abort = m_pend && (m_pend_child == abort_child);
      mate_done = m_pend;
      m_pend = mate_start;
      m_pend_child = int'(child_idx);
    end
  end

  // ---------------- model and checking ----------------
  typedef struct { int kind; int a; int b; int c; } evt_t;
  evt_t exp_q[$];
  int   exp_arr [POP];
  int   exp_gen, exp_best;
  int   n_fit = 0, n_sort = 0, n_mate = 0;
  int   n_checks = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  // Request sequence and end state of a run of g generations.
  task automatic build_model(input int g);
    bit stop = 1'b0;
    exp_q.delete();
    exp_best = (1 << W) - 1;
    exp_gen  = 0;
    for (int gi = 0; gi < g && !stop; gi++) begin
      for (int i = 0; i < POP && !stop; i++) begin
        exp_q.push_back('{0, i, 0, 0});
        exp_arr[i] = vals[i];
        if (vals[i] < exp_best) exp_best = vals[i];
        if (EARLY && vals[i] == 0) stop = 1'b1;
      end
      if (!stop) begin
        exp_q.push_back('{1, 0, 0, 0});
        for (int c = 2; c < POP; c++) exp_q.push_back('{2, c, (c - 2) % H, (c - 1) % H});
        exp_gen = (gi + 1 > 255) ? 255 : gi + 1;
      end
    end
  endtask

  task automatic expect_evt(input int k, input int a, input int b, input int c);
    evt_t e;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL unexpected_pulse: kind %0d idx %0d seen, none expected", k, a);
    end else begin
      e = exp_q.pop_front();
      chk("pulse_kind", k, e.kind);
      chk("pulse_idx", a, e.a);
      if (k == 2) begin
        chk("mate_p1", b, e.b);
        chk("mate_p2", c, e.c);
      end
    end
  endtask

  // Per-cycle check of every request pulse against the model sequence.
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (fit_start)  begin n_fit++;  expect_evt(0, int'(fit_idx), 0, 0); end
        if (sort_start) begin n_sort++; expect_evt(1, 0, 0, 0); end
        if (mate_start) begin
          n_mate++;
          expect_evt(2, int'(child_idx), int'(mate_p1_rank), int'(mate_p2_rank));
        end
        chk("busy_and_done_exclusive", busy && done, 1'b0);
      end
    end
  endtask

  task automatic start_run(input int mg);
    @(negedge clk);
    max_gen = GW'(mg);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk(nm, done, 1'b1);
  endtask

  task automatic final_check(input string nm);
    chk({nm, "_pending_requests"}, exp_q.size(), 0);
    chk({nm, "_done"}, done, 1'b1);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_generation"}, generation, exp_gen);
    chk({nm, "_best"}, best_fitness, exp_best);
    for (int i = 0; i < POP; i++) chk({nm, "_array"}, fitness_array[i*W +: W], exp_arr[i]);
  endtask

  initial begin
    int bf, bs, bm, k;
    for (int i = 0; i < POP; i++) begin vals[i] = 0; exp_arr[i] = 0; end
    fork compare_loop(); join_none

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_generation", generation, 0);
    chk("rst_best", best_fitness, 5'd31);
    chk("rst_fit_idx", fit_idx, 0);
    chk("rst_child_idx", child_idx, 0);
    chk("rst_array", fitness_array, 0);

    // One generation from IDLE
    vals = '{9, 3, 7, 12, 20, 5, 30, 8, 15, 4};
    build_model(1);
    bf = n_fit; bs = n_sort; bm = n_mate;
    start_run(1);
    wait_done("g1_done_timeout");
    final_check("g1");
    chk("g1_fit_pulses", n_fit - bf, 10);
    chk("g1_sort_pulses", n_sort - bs, 1);
    chk("g1_mate_pulses", n_mate - bm, 8);
    chk("g1_gen_lit", generation, 8'd1);
    chk("g1_best_lit", best_fitness, 5'd3);
    chk("g1_arr0_lit", fitness_array[0 +: W], 5'd9);
    chk("g1_arr1_lit", fitness_array[W +: W], 5'd3);
    chk("g1_arr2_lit", fitness_array[2*W +: W], 5'd7);

    // Two generations, restarted from FINISH
    vals = '{14, 6, 22, 11, 9, 17, 25, 13, 10, 19};
    build_model(2);
    bf = n_fit; bs = n_sort; bm = n_mate;
    start_run(2);
    wait_done("g2_done_timeout");
    final_check("g2");
    chk("g2_fit_pulses", n_fit - bf, 20);
    chk("g2_sort_pulses", n_sort - bs, 2);
    chk("g2_mate_pulses", n_mate - bm, 16);
    chk("g2_best_lit", best_fitness, 5'd6);

    // max_gen = 0: straight to FINISH, no requests
    build_model(0);
    bf = n_fit; bs = n_sort; bm = n_mate;
    start_run(0);
    chk("g0_done_next_cycle", done, 1'b1);
    chk("g0_busy", busy, 1'b0);
    repeat (5) @(negedge clk);
    chk("g0_no_pulses", (n_fit - bf) + (n_sort - bs) + (n_mate - bm), 0);
    chk("g0_done_held", done, 1'b1);
    chk("g0_generation", generation, 8'd0);
    chk("g0_best_reset", best_fitness, 5'd31);

    // Abort coincident with mate_done for child 4
    build_model(1);
    bm = n_mate;
    abort_child = 4;
    start_run(1);
    k = 0;
    while (busy && k < 3000) begin @(negedge clk); k++; end
    abort_child = -1;
    exp_q.delete();
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_mates_before", n_mate - bm, 3);
    repeat (10) @(negedge clk);
    chk("abort_mates_after", n_mate - bm, 3);
    chk("abort_still_idle", busy, 1'b0);

    // Start and spurious sort_done while busy; sort_done coincident with the pulse
    vals = '{8, 12, 5, 21, 16, 9, 27, 11, 6, 18};
    build_model(1);
    bm = n_mate;
    sort_auto = 1'b0;
    start_run(1);
    repeat (4) @(negedge clk);
    start = 1'b1; man_sort_done = 1'b1;
    @(negedge clk);
    start = 1'b0; man_sort_done = 1'b0;
    chk("spur_busy", busy, 1'b1);
    k = 0;
    while (!sort_start && k < 3000) begin @(negedge clk); k++; end
    chk("spur_sort_seen", sort_start, 1'b1);
    man_sort_done = 1'b1;
    @(negedge clk);
    man_sort_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("spur_no_early_mate", mate_start, 1'b0);
      @(negedge clk);
    end
    chk("spur_no_mates", n_mate - bm, 0);
    man_sort_done = 1'b1;
    @(negedge clk);
    man_sort_done = 1'b0;
    wait_done("spur_done_timeout");
    sort_auto = 1'b1;
    final_check("spur");

    // Third score is a perfect match
    vals = '{9, 3, 0, 12, 20, 5, 30, 8, 15, 4};
    build_model(1);
    bf = n_fit; bs = n_sort;
    start_run(1);
    wait_done("exit_done_timeout");
    final_check("exit");
    chk("exit_best_lit", best_fitness, 5'd0);
    if (EARLY) begin
      chk("exit_fit_pulses", n_fit - bf, 3);
      chk("exit_sort_pulses", n_sort - bs, 0);
      chk("exit_gen_lit", generation, 8'd0);
    end else begin
      chk("exit_fit_pulses", n_fit - bf, 10);
      chk("exit_sort_pulses", n_sort - bs, 1);
      chk("exit_gen_lit", generation, 8'd1);
    end

    // Reset in the middle of a run
    build_model(2);
    start_run(2);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    for (int i = 0; i < POP; i++) exp_arr[i] = 0;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_fit_start", fit_start, 1'b0);
    chk("mrst_generation", generation, 0);
    chk("mrst_best", best_fitness, 5'd31);
    chk("mrst_fit_idx", fit_idx, 0);
    chk("mrst_child_idx", child_idx, 0);
    chk("mrst_p1", mate_p1_rank, 0);
    chk("mrst_p2", mate_p2_rank, 0);
    chk("mrst_array", fitness_array, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("mrst_stays_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
